// File: rtl/seq_serializer_if.sv
// seq_serializer_if: pattern handshake in, serial bit stream and frame status out.
interface seq_serializer_if #(
    parameter int WIDTH = 12,
    parameter int CNT_W = 8
);
    logic             pat_valid;
    logic [WIDTH-1:0] pat_data;
    logic             pat_clr;
    logic             pat_ready;
    logic             seq;
    logic             seq_valid;
    logic             det_clr;
    logic             done;
    logic [CNT_W-1:0] pat_cnt;

    modport master (
        output pat_valid, pat_data, pat_clr,
        input  pat_ready, seq, seq_valid, det_clr, done, pat_cnt
    );

    modport slave (
        input  pat_valid, pat_data, pat_clr,
        output pat_ready, seq, seq_valid, det_clr, done, pat_cnt
    );
endinterface

// File: rtl/seq_serializer.sv
// seq_serializer: MSB-first pattern serializer with optional detector-clear cycle.
// Define SEQ_SER_REPEAT_EN to add the rpt input that replays the stored pattern gaplessly.
module seq_serializer #(
    parameter int WIDTH = 12,
    parameter int CNT_W = 8
) (
    input logic clk,
    input logic reset,
`ifdef SEQ_SER_REPEAT_EN
    input logic rpt,
`endif
    seq_serializer_if.slave bus
);
    localparam int IW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             seq_q, seq_d;
    logic             vld_q, vld_d;
    logic             clr_q, clr_d;
    logic             done_q, done_d;
    logic             rdy_q, rdy_d;
    logic             rep;

`ifdef SEQ_SER_REPEAT_EN
    assign rep = rpt;
`else
    assign rep = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (bus.pat_valid && rdy_q) begin
                pat_d   = bus.pat_data;
                idx_d   = IW'(WIDTH - 1);
                state_d = bus.pat_clr ? CLEAR : SHIFT;
            end
            CLEAR: state_d = SHIFT;
            SHIFT: if (idx_q == '0) begin
                cnt_d   = cnt_q + 1'b1;
                idx_d   = IW'(WIDTH - 1);
                state_d = rep ? SHIFT : IDLE;
            end else begin
                idx_d = idx_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // outputs describe the cycle that the next state will occupy
        rdy_d  = state_d == IDLE;
        clr_d  = state_d == CLEAR;
        vld_d  = state_d == SHIFT;
        seq_d  = vld_d & pat_d[idx_d];
        done_d = vld_d && idx_d == '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            seq_q   <= 1'b0;
            vld_q   <= 1'b0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            seq_q   <= seq_d;
            vld_q   <= vld_d;
            clr_q   <= clr_d;
            done_q  <= done_d;
            rdy_q   <= rdy_d;
        end
    end

    assign bus.pat_ready = rdy_q;
    assign bus.seq       = seq_q;
    assign bus.seq_valid = vld_q;
    assign bus.det_clr   = clr_q;
    assign bus.done      = done_q;
    assign bus.pat_cnt   = cnt_q;
endmodule

// File: tb/tb_seq_serializer.sv
// tb_seq_serializer: randomized self-checking bench against a frame-level reference model.
module tb_seq_serializer;
    localparam int W  = 12;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
`ifdef SEQ_SER_REPEAT_EN
    logic rpt = 1'b0;
`endif
    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    seq_serializer_if #(.WIDTH(W), .CNT_W(CW)) bus ();
    seq_serializer_if #(.WIDTH(W), .CNT_W(2))  bus2 ();

    seq_serializer #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk),
        .reset(reset),
`ifdef SEQ_SER_REPEAT_EN
        .rpt(rpt),
`endif
        .bus(bus)
    );

    seq_serializer #(.WIDTH(W), .CNT_W(2)) dut2 (
        .clk(clk),
        .reset(reset),
`ifdef SEQ_SER_REPEAT_EN
        .rpt(1'b0),
`endif
        .bus(bus2)
    );

    function automatic logic [4:0] outs();
        return {bus.det_clr, bus.seq_valid, bus.seq, bus.done, bus.pat_ready};
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!bus.pat_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.pat_ready !== 1'b1) begin
            errors++;
            $display("FAIL wait_ready: pat_ready=%b required 1", bus.pat_ready);
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (outs() !== 5'b00001 || bus.pat_cnt !== CW'(exp_cnt)) begin
            errors++;
            $display("FAIL %s idle: outs=%b cnt=%0d required outs=00001 cnt=%0d", name, outs(), bus.pat_cnt, exp_cnt);
        end
    endtask

    task automatic send_frame(input logic [W-1:0] data, input logic clr);
        logic [4:0] want;
        int n;
        wait_ready();
        bus.pat_valid = 1'b1;
        bus.pat_data  = data;
        bus.pat_clr   = clr;
        n = clr ? W + 1 : W;
        for (int i = 0; i < n; i++) begin
            int b;
            @(negedge clk);
            b = clr ? i - 1 : i;
            want = (clr && i == 0) ? 5'b10000 : {1'b0, 1'b1, data[W-1-((b < 0) ? 0 : b)], b == W - 1, 1'b0};
            checks++;
            if (outs() !== want) begin
                errors++;
                $display("FAIL frame %h clr=%b cycle %0d: outs=%b required %b", data, clr, i, outs(), want);
            end
            bus.pat_valid = 1'($urandom);
            bus.pat_data  = W'($urandom);
            bus.pat_clr   = 1'($urandom);
        end
        bus.pat_valid = 1'b0;
        exp_cnt = (exp_cnt + 1) % (1 << CW);
        @(negedge clk);
        check_idle("frame");
    endtask

    task automatic test_reset();
        bus.pat_valid = 1'b0; bus.pat_data = '0; bus.pat_clr = 1'b0;
        bus2.pat_valid = 1'b0; bus2.pat_data = '0; bus2.pat_clr = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (outs() !== 5'b0 || bus.pat_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state: outs=%b cnt=%0d required 00000 cnt=0", outs(), bus.pat_cnt);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.pat_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: pat_ready=%b required 0", bus.pat_ready);
        end
        @(negedge clk);
        check_idle("reset_release");
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp_q[$];
        logic [W-1:0] p0 = 12'hFFF;
        logic [W-1:0] p1 = 12'h001;
        int sent = 0;
        logic pend;
        wait_ready();
        for (int i = 0; i < W; i++) exp_q.push_back({1'b1, p0[W-1-i], i == W - 1});
        exp_q.push_back(3'b000);
        for (int i = 0; i < W; i++) exp_q.push_back({1'b1, p1[W-1-i], i == W - 1});
        exp_q.push_back(3'b000);
        bus.pat_valid = 1'b1; bus.pat_data = p0; bus.pat_clr = 1'b0;
        pend = 1'b1;
        for (int c = 0; c < 2 * W + 2; c++) begin
            @(negedge clk);
            if (pend) begin
                sent++;
                bus.pat_data = p1;
                if (sent == 2) bus.pat_valid = 1'b0;
            end
            checks++;
            if ({bus.seq_valid, bus.seq, bus.done} !== exp_q[c]) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: {vld,seq,done}=%b required %b", c, {bus.seq_valid, bus.seq, bus.done}, exp_q[c]);
            end
            pend = bus.pat_valid && bus.pat_ready;
        end
        checks++;
        if (sent != 2) begin
            errors++;
            $display("FAIL back_to_back transfers: %0d required 2", sent);
        end
        exp_cnt = (exp_cnt + 2) % (1 << CW);
        check_idle("back_to_back");
    endtask

    task automatic test_random();
        for (int k = 0; k < 20; k++) send_frame(W'($urandom), 1'($urandom));
    endtask

    task automatic test_reset_mid_frame();
        logic [W-1:0] d = 12'hAAA;
        wait_ready();
        bus.pat_valid = 1'b1; bus.pat_data = d; bus.pat_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.pat_valid = 1'b0;
            checks++;
            if (outs() !== {2'b01, d[W-1-i], 2'b00}) begin
                errors++;
                $display("FAIL mid_frame bit %0d: outs=%b required %b", i, outs(), {2'b01, d[W-1-i], 2'b00});
            end
        end
        reset = 1'b0;
        #1;
        checks++;
        if (outs() !== 5'b0 || bus.pat_cnt !== '0) begin
            errors++;
            $display("FAIL mid_frame_abort: outs=%b cnt=%0d required 00000 cnt=0", outs(), bus.pat_cnt);
        end
        exp_cnt = 0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_idle("after_abort");
        send_frame(W'($urandom), 1'b0);
    endtask

    task automatic test_cnt_wrap();
        for (int k = 0; k < 5; k++) begin
            int n = 0;
            int e = (k + 1) % 4;
            while (!bus2.pat_ready && n < 50) begin @(negedge clk); n++; end
            bus2.pat_valid = 1'b1;
            bus2.pat_data  = W'($urandom);
            bus2.pat_clr   = 1'($urandom);
            @(negedge clk);
            bus2.pat_valid = 1'b0;
            n = 0;
            while (!bus2.done && n < 20) begin @(negedge clk); n++; end
            @(negedge clk);
            checks++;
            if (bus2.pat_cnt !== e[1:0]) begin
                errors++;
                $display("FAIL cnt_wrap frame %0d: pat_cnt=%0d required %0d", k, bus2.pat_cnt, e);
            end
        end
    endtask

`ifdef SEQ_SER_REPEAT_EN
    task automatic test_repeat();
        logic [W-1:0] d = 12'h801;
        logic [4:0] want;
        wait_ready();
        rpt = 1'b1;
        bus.pat_valid = 1'b1; bus.pat_data = d; bus.pat_clr = 1'b0;
        for (int i = 0; i < 3 * W; i++) begin
            @(negedge clk);
            bus.pat_valid = 1'($urandom);
            bus.pat_data  = W'($urandom);
            if (i == 2 * W) rpt = 1'b0;
            want = {2'b01, d[W-1-(i%W)], (i % W) == W - 1, 1'b0};
            checks++;
            if (outs() !== want) begin
                errors++;
                $display("FAIL repeat cycle %0d: outs=%b required %b", i, outs(), want);
            end
        end
        bus.pat_valid = 1'b0;
        exp_cnt = (exp_cnt + 3) % (1 << CW);
        @(negedge clk);
        check_idle("repeat");
    endtask
`endif

    initial begin
        test_reset();
        send_frame(12'h937, 1'b0);
        send_frame(12'h937, 1'b1);
        test_back_to_back();
        test_random();
        test_reset_mid_frame();
        test_cnt_wrap();
`ifdef SEQ_SER_REPEAT_EN
        test_repeat();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
